// File: rtl/b2p_stream_arbiter_if.sv
// Handshake bundle between the byte-stream requesters, the arbiter and the
// downstream byte-to-packet packer. The master modport is the arbiter side;
// the slave modport is the environment (requesters plus packer).
interface b2p_stream_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int BITS_PER_BYTE = 8,
  parameter int CH_W          = 2
) ();

  logic [NUM_REQ*BITS_PER_BYTE-1:0] asi_in_data;
  logic [NUM_REQ-1:0]               asi_in_valid;
  logic [NUM_REQ-1:0]               asi_in_ready;
  logic [BITS_PER_BYTE-1:0]         aso_out_data;
  logic                             aso_out_valid;
  logic                             aso_out_ready;
  logic [CH_W-1:0]                  aso_out_channel;

  modport master (
    input  asi_in_data,
    input  asi_in_valid,
    output asi_in_ready,
    output aso_out_data,
    output aso_out_valid,
    input  aso_out_ready,
    output aso_out_channel
  );

  modport slave (
    output asi_in_data,
    output asi_in_valid,
    input  asi_in_ready,
    input  aso_out_data,
    input  aso_out_valid,
    output aso_out_ready,
    input  aso_out_channel
  );

endinterface

// File: rtl/b2p_stream_arbiter.sv
// Packet-granular round-robin arbiter in front of a fixed-length
// byte-to-packet packer. One requester owns the packer for exactly
// BYTES_PER_PACKET accepted beats, then the grant is re-arbitrated starting
// just after the requester that was last served.
module b2p_stream_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int BITS_PER_BYTE    = 8,
  parameter int BYTES_PER_PACKET = 2048,
  parameter int CH_W             = 2
) (
  input  logic                       clock_clk,
  input  logic                       reset_reset,
  input  logic                       cfg_enable,
  input  logic [NUM_REQ-1:0]         cfg_mask,
  b2p_stream_arbiter_if.master       bus,
  output logic                       busy,
  output logic                       pkt_done
);

  localparam int CNT_W = $clog2(BYTES_PER_PACKET);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BYTES_PER_PACKET - 1);
  localparam logic [CH_W-1:0]  LAST_REQ  = CH_W'(NUM_REQ - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]               state_q,   state_d;
  logic [CH_W-1:0]          grant_q,   grant_d;
  logic [CH_W-1:0]          rrPtr_q,   rrPtr_d;
  logic [CNT_W-1:0]         beatCnt_q, beatCnt_d;
  logic                     busy_q,    busy_d;

  logic [NUM_REQ-1:0]       elig;
  logic                     pickValid;
  logic [CH_W-1:0]          pick;
  logic                     selValid;
  logic [BITS_PER_BYTE-1:0] selData;
  logic                     inXfer;
  logic                     beat;
  logic                     lastBeat;

  assign inXfer   = (state_q == XFER);
  assign beat     = inXfer & selValid & bus.aso_out_ready;
  assign lastBeat = beat & (beatCnt_q == LAST_BEAT);

  assign pkt_done            = lastBeat;
  assign busy                = busy_q;
  assign bus.aso_out_channel = grant_q;
  assign bus.aso_out_valid   = inXfer & selValid;
  assign bus.aso_out_data    = selData;

  // Round-robin pick: first eligible requester at or above rrPtr, wrapping;
  // scanning from the far end lets the closest candidate overwrite the rest.
  always_comb begin
    int idx;
    elig      = bus.asi_in_valid & cfg_mask & {NUM_REQ{cfg_enable}};
    pickValid = 1'b0;
    pick      = '0;
    idx       = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(rrPtr_q) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (elig[idx]) begin
        pickValid = 1'b1;
        pick      = CH_W'(idx);
      end
    end
  end

  // Zero-latency mux from the granted lane to the packer, with ready steered
  // back only to the granted requester while a packet is in flight.
  always_comb begin
    selValid         = 1'b0;
    selData          = '0;
    bus.asi_in_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == CH_W'(i)) begin
        selValid = bus.asi_in_valid[i];
        selData  = bus.asi_in_data[i*BITS_PER_BYTE +: BITS_PER_BYTE];
        if (inXfer) begin
          bus.asi_in_ready[i] = bus.aso_out_ready;
        end
      end
    end
  end

  // Next-state logic: grant on arbitration, count beats, release on the last
  // beat and move the round-robin pointer past the requester just served.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rrPtr_d   = rrPtr_q;
    beatCnt_d = beatCnt_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          grant_d = pick;
          busy_d  = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (lastBeat) begin
          beatCnt_d = '0;
          busy_d    = 1'b0;
          rrPtr_d   = (grant_q == LAST_REQ) ? '0 : grant_q + CH_W'(1);
          state_d   = IDLE;
        end else if (beat) begin
          beatCnt_d = beatCnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any partial packet immediately.
  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rrPtr_q   <= '0;
      beatCnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rrPtr_q   <= rrPtr_d;
      beatCnt_q <= beatCnt_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_b2p_stream_arbiter.sv
// Directed bench for the packet arbiter with 4-beat packets and 4 requesters.
module tb_b2p_stream_arbiter;

  localparam int NUM_REQ = 4;
  localparam int BPB     = 8;
  localparam int BPP     = 4;
  localparam int CH_W    = 2;

  logic       clock_clk = 1'b0;
  logic       reset_reset;
  logic       cfgEnable;
  logic [3:0] cfgMask;
  logic       busy;
  logic       pktDone;

  int vectors     = 0;
  int miscompares = 0;

  b2p_stream_arbiter_if #(.NUM_REQ(NUM_REQ), .BITS_PER_BYTE(BPB), .CH_W(CH_W)) busIf ();

  b2p_stream_arbiter #(
    .NUM_REQ(NUM_REQ),
    .BITS_PER_BYTE(BPB),
    .BYTES_PER_PACKET(BPP),
    .CH_W(CH_W)
  ) dut (
    .clock_clk  (clock_clk),
    .reset_reset(reset_reset),
    .cfg_enable (cfgEnable),
    .cfg_mask   (cfgMask),
    .bus        (busIf),
    .busy       (busy),
    .pkt_done   (pktDone)
  );

  // Free-running clock, period 10.
  always #5 clock_clk = ~clock_clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic expOV, input logic [3:0] expIR,
                          input logic [7:0] expData, input logic [1:0] expCh,
                          input logic expBusy, input logic expPd);
    #1;
    checkOutput({tag, ".valid"},   32'(busIf.aso_out_valid),   32'(expOV));
    checkOutput({tag, ".ready"},   32'(busIf.asi_in_ready),    32'(expIR));
    checkOutput({tag, ".channel"}, 32'(busIf.aso_out_channel), 32'(expCh));
    checkOutput({tag, ".busy"},    32'(busy),                  32'(expBusy));
    checkOutput({tag, ".pktDone"}, 32'(pktDone),               32'(expPd));
    if (expOV) begin
      checkOutput({tag, ".data"}, 32'(busIf.aso_out_data), 32'(expData));
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic outReady);
    @(negedge clock_clk);
    busIf.asi_in_valid  = valid;
    busIf.aso_out_ready = outReady;
  endtask

  task automatic setLane(input int lane, input logic [7:0] value);
    busIf.asi_in_data[lane*BPB +: BPB] = value;
  endtask

  initial begin
    logic [1:0] rrOrder [5];
    logic [1:0] ch;
    logic [1:0] prevCh;
    rrOrder = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    reset_reset         = 1'b1;
    cfgEnable           = 1'b1;
    cfgMask             = 4'b1111;
    busIf.asi_in_data   = '0;
    busIf.asi_in_valid  = '0;
    busIf.aso_out_ready = 1'b0;
    checkAll("reset", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);

    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    reset_reset = 1'b0;

    for (int c = 0; c < 20; c++) begin
      applyStimulus(4'b0000, 1'b1);
      checkAll("idle", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
    end

    for (int i = 0; i < NUM_REQ; i++) setLane(i, 8'hA0 + 8'(i));
    prevCh = 2'd0;
    for (int p = 0; p < 5; p++) begin
      ch = rrOrder[p];
      applyStimulus(4'b1111, 1'b1);
      checkAll("rrGap", 1'b0, 4'b0000, 8'h00, prevCh, 1'b0, 1'b0);
      for (int b = 0; b < BPP; b++) begin
        applyStimulus(4'b1111, 1'b1);
        checkAll("rrBeat", 1'b1, 4'b0001 << ch, 8'hA0 + 8'(ch), ch, 1'b1, b == BPP - 1);
      end
      prevCh = ch;
    end

    applyStimulus(4'b0010, 1'b1);
    setLane(1, 8'h10);
    checkAll("singleIdle", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
    for (int b = 0; b < BPP; b++) begin
      applyStimulus(4'b0010, 1'b1);
      setLane(1, 8'h10 + 8'(b));
      checkAll("single", 1'b1, 4'b0010, 8'h10 + 8'(b), 2'd1, 1'b1, b == BPP - 1);
    end

    applyStimulus(4'b0100, 1'b1);
    setLane(2, 8'h20);
    checkAll("singleDone", 1'b0, 4'b0000, 8'h00, 2'd1, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    checkAll("bp1", 1'b1, 4'b0100, 8'h20, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    setLane(2, 8'h21);
    checkAll("bp2", 1'b1, 4'b0000, 8'h21, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    checkAll("bp3", 1'b1, 4'b0100, 8'h21, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    setLane(2, 8'h22);
    checkAll("stall1", 1'b0, 4'b0000, 8'h00, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkAll("stall2", 1'b0, 4'b0100, 8'h00, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkAll("stall3", 1'b0, 4'b0000, 8'h00, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    checkAll("bp7", 1'b1, 4'b0100, 8'h22, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    setLane(2, 8'h23);
    checkAll("bp8", 1'b1, 4'b0000, 8'h23, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    checkAll("bp9", 1'b1, 4'b0100, 8'h23, 2'd2, 1'b1, 1'b1);

    applyStimulus(4'b0010, 1'b1);
    setLane(1, 8'h30);
    checkAll("maskIdle", 1'b0, 4'b0000, 8'h00, 2'd2, 1'b0, 1'b0);
    for (int b = 0; b < BPP; b++) begin
      applyStimulus(4'b0010, 1'b1);
      setLane(1, 8'h30 + 8'(b));
      if (b == 1) cfgMask = 4'b1101;
      checkAll("maskPkt", 1'b1, 4'b0010, 8'h30 + 8'(b), 2'd1, 1'b1, b == BPP - 1);
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b0010, 1'b1);
      checkAll("maskSkip", 1'b0, 4'b0000, 8'h00, 2'd1, 1'b0, 1'b0);
    end

    applyStimulus(4'b0010, 1'b1);
    cfgMask = 4'b1111;
    checkAll("enIdle", 1'b0, 4'b0000, 8'h00, 2'd1, 1'b0, 1'b0);
    for (int b = 0; b < BPP; b++) begin
      applyStimulus(4'b1111, 1'b1);
      if (b == 0) cfgEnable = 1'b0;
      setLane(1, 8'h40 + 8'(b));
      checkAll("enPkt", 1'b1, 4'b0010, 8'h40 + 8'(b), 2'd1, 1'b1, b == BPP - 1);
    end
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'b1111, 1'b1);
      checkAll("enOff", 1'b0, 4'b0000, 8'h00, 2'd1, 1'b0, 1'b0);
    end

    applyStimulus(4'b1111, 1'b1);
    cfgEnable = 1'b1;
    setLane(2, 8'hA2);
    checkAll("rstIdle", 1'b0, 4'b0000, 8'h00, 2'd1, 1'b0, 1'b0);
    for (int b = 0; b < 2; b++) begin
      applyStimulus(4'b1111, 1'b1);
      checkAll("rstPre", 1'b1, 4'b0100, 8'hA2, 2'd2, 1'b1, 1'b0);
    end
    applyStimulus(4'b1111, 1'b1);
    reset_reset = 1'b1;
    checkAll("rstAsync", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b1);
    reset_reset = 1'b0;
    checkAll("rstRelease", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
    for (int b = 0; b < BPP; b++) begin
      applyStimulus(4'b1111, 1'b1);
      checkAll("afterRst", 1'b1, 4'b0001, 8'hA0, 2'd0, 1'b1, b == BPP - 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
